traffic_timebase: RTL and testbench
===================================

// Module: traffic_timebase
// PURPOSE
//   Front-end stage feeding the traffic-light controller. Produces a single-cycle
//   step enable (tick) and a blink phase from the 100 MHz board clock; the
//   controller runs on clk gated by tick, so no derived clock exists.
//   Conditions the raw pedestrian button (BTNU) into a sticky request that the
//   controller clears with an acknowledge.
// PARAMETERS
//   CLK_HZ   100_000_000  input clock frequency, Hz
//   TICK_HZ  3            tick rate, Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2, else elaboration error
//   DB_CYC   1_000_000    debounce qualification length, clk cycles (10 ms); DB_CYC >= 1
// PORTS
//   clk      in   1  system clock (CLK100MHZ)
//   clr_n    in   1  asynchronous active-low reset
//   en       in   1  run enable for the prescaler; low = pause
//   btn_raw  in   1  asynchronous, bouncing pedestrian button
//   req_ack  in   1  from controller: request served, clear ped_req
//   tick     out  1  one-clk pulse every DIV clks while en high
//   blink    out  1  toggles on every tick (flashing-amber phase)
//   btn_db   out  1  debounced button level
//   ped_req  out  1  sticky pedestrian request
// BEHAVIOUR
//   Reset (clr_n low, async): tick=0, blink=0, btn_db=0, ped_req=0;
//     prescaler, sync flops and debounce counter = 0. Release is synchronous to clk.
//   Prescaler: cnt width $clog2(DIV); counts only when en=1.
//     - At cnt==DIV-1 with en=1: cnt->0, tick registered high next cycle, exactly 1 clk.
//     - Otherwise cnt+1; tick=0.
//     - en=0: cnt holds, tick=0, blink holds; resume continues from held cnt.
//     - First tick: DIV-th rising edge after reset release with en held high;
//       period exactly DIV clks thereafter.
//   blink: inverts in the same cycle tick is high (registered together).
//   Synchroniser: 2 flops, btn_raw -> btn_s; 2-clk latency, no other logic on btn_raw.
//   Debounce: counter dbc with $clog2(DB_CYC+1) bits.
//     - btn_s != btn_db: dbc+1; when dbc reaches DB_CYC-1, btn_db<=btn_s and dbc<=0.
//     - btn_s == btn_db: dbc<=0 (any bounce restarts qualification).
//     - Press-to-btn_db latency = 2 + DB_CYC clks for a clean edge.
//   Request:
//     - btn_db rising edge (registered btn_db 0->1) sets ped_req next cycle.
//     - req_ack=1 clears ped_req next cycle.
//     - Set and ack in the same cycle: ped_req stays 1 (new press never lost).
//     - Further presses while ped_req=1 have no effect; release never clears.
//     - req_ack while ped_req=0: no effect.
//   Reset mid-operation: everything returns to reset values immediately; a button
//     held through reset must re-qualify (btn_db rises after 2+DB_CYC clks) and
//     then raises ped_req.
// STRUCTURE
//   Package traffic_pkg: CLK_HZ, default TICK_HZ, DB_CYC constants; 6-bit light
//   encoding shared with the controller (R/Y/G per direction).
//   Sub-module sync_debounce (2-flop sync + debounce counter, outputs btn_db);
//   prescaler, blink and request latch stay in traffic_timebase.
// TESTING  (bench params: CLK_HZ=100, TICK_HZ=10 -> DIV=10, DB_CYC=4)
//   1 Reset release, en=1 -> tick high on clks 10,20,30 only; blink 0->1->0->1.
//   2 en=0 at clk 14 for 5 clks -> no tick; next tick at clk 25; blink held.
//   3 btn_raw 1 clean at clk 0 -> btn_db=1 at clk 6, ped_req=1 at clk 7.
//   4 btn_raw bounce 1,0,1,0 each 2 clks then steady 1 -> btn_db rises only 2+4
//     clks after last edge; exactly one ped_req set.
//   5 ped_req=1, req_ack pulse in same cycle as new btn_db rise -> ped_req stays 1;
//     lone req_ack pulse later -> ped_req=0 next clk.
//   6 clr_n low mid-period with ped_req=1 and btn held -> all outputs 0 at once;
//     after release ped_req re-asserts at clk 7, first tick at clk 10.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light slice: board timing defaults and the
// 6-bit light encoding exchanged with the controller.
package traffic_pkg;

    localparam int CLK_HZ  = 100_000_000;
    localparam int TICK_HZ = 3;
    localparam int DB_CYC  = 1_000_000;

    // One lamp group per direction, {red, yellow, green}; NS in [5:3], EW in [2:0].
    typedef enum logic [2:0] {
        LAMP_OFF = 3'b000,
        LAMP_GRN = 3'b001,
        LAMP_YEL = 3'b010,
        LAMP_RED = 3'b100
    } lamp_e;

    typedef logic [5:0] light_t;

    localparam light_t LIGHT_ALL_RED = 6'b100_100;
    localparam light_t LIGHT_NS_GO   = 6'b001_100;
    localparam light_t LIGHT_NS_WARN = 6'b010_100;
    localparam light_t LIGHT_EW_GO   = 6'b100_001;
    localparam light_t LIGHT_EW_WARN = 6'b100_010;
    localparam light_t LIGHT_DARK    = 6'b000_000;

    function automatic light_t make_light(input lamp_e ns, input lamp_e ew);
        return {ns, ew};
    endfunction

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a qualification counter: the debounced
// level only follows the input after DB_CYC consecutive disagreeing cycles.
module sync_debounce #(
    parameter int DB_CYC = traffic_pkg::DB_CYC
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_raw,
    output logic btn_db
);
    import traffic_pkg::*;

    localparam int DBW = $clog2(DB_CYC + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);

    generate
        if (DB_CYC < 1) begin : g_db_check
            $error("sync_debounce: DB_CYC must be at least 1");
        end
    endgenerate

    logic           r_sync1;
    logic           r_sync2;
    logic [DBW-1:0] r_dbc;
    logic           r_db;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where the synchronised input agrees with the output restarts qualification.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_dbc <= '0;
            r_db  <= 1'b0;
        end else if (r_sync2 == r_db) begin
            r_dbc <= '0;
        end else if (r_dbc == DB_LAST) begin
            r_dbc <= '0;
            r_db  <= r_sync2;
        end else begin
            r_dbc <= r_dbc + DBW'(1);
        end
    end

    assign btn_db = r_db;

endmodule

// File: rtl/traffic_timebase.sv
// Timebase front end for the traffic-light controller: step tick, blink phase
// and a sticky pedestrian request built from the debounced button.
module traffic_timebase #(
    parameter int CLK_HZ  = traffic_pkg::CLK_HZ,
    parameter int TICK_HZ = traffic_pkg::TICK_HZ,
    parameter int DB_CYC  = traffic_pkg::DB_CYC
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic btn_raw,
    input  logic req_ack,
    output logic tick,
    output logic blink,
    output logic btn_db,
    output logic ped_req
);
    import traffic_pkg::*;

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("traffic_timebase: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          r_blink;
    logic          r_db_q;
    logic          r_ped_req;
    logic          w_btn_db;
    logic          w_db_rise;

    // Pausing freezes the count so a resumed period is not shortened or restarted.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_blink <= 1'b0;
        end else if (en && r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_tick  <= 1'b1;
            r_blink <= ~r_blink;
        end else begin
            r_tick <= 1'b0;
            if (en) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    sync_debounce #(
        .DB_CYC (DB_CYC)
    ) u_sync_debounce (
        .clk     (clk),
        .clr_n   (clr_n),
        .btn_raw (btn_raw),
        .btn_db  (w_btn_db)
    );

    assign w_db_rise = w_btn_db & ~r_db_q;

    // A new press wins over a simultaneous acknowledge so no request is dropped.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_db_q    <= 1'b0;
            r_ped_req <= 1'b0;
        end else begin
            r_db_q <= w_btn_db;
            if (w_db_rise) begin
                r_ped_req <= 1'b1;
            end else if (req_ack) begin
                r_ped_req <= 1'b0;
            end
        end
    end

    assign tick    = r_tick;
    assign blink   = r_blink;
    assign btn_db  = w_btn_db;
    assign ped_req = r_ped_req;

endmodule

// File: tb/tb_traffic_timebase.sv
// Scoreboard bench for traffic_timebase with DIV=10 and DB_CYC=4; clk N means
// the sample taken after the N-th rising edge following reset release.
module tb_traffic_timebase;

    logic clk = 1'b0;
    logic clr_n;
    logic en;
    logic btn_raw;
    logic req_ack;
    logic tick;
    logic blink;
    logic btn_db;
    logic ped_req;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    ev_t  tickQ[$];
    int   dbQ[$];
    int   reqQ[$];
    logic reqExpQ[$];

    traffic_timebase #(
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .DB_CYC  (4)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .en      (en),
        .btn_raw (btn_raw),
        .req_ack (req_ack),
        .tick    (tick),
        .blink   (blink),
        .btn_db  (btn_db),
        .ped_req (ped_req)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic applyReset(input logic btnLevel);
        @(negedge clk);
        clr_n   = 1'b0;
        en      = 1'b1;
        req_ack = 1'b0;
        btn_raw = btnLevel;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;
        tickQ.delete();
        dbQ.delete();
        reqQ.delete();
        reqExpQ.delete();
    endtask

    task automatic test_reset();
        clr_n   = 1'b1;
        en      = 1'b1;
        btn_raw = 1'b1;
        req_ack = 1'b0;
        #1 clr_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++;
            if ({tick, blink, btn_db, ped_req} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs: {tick,blink,btn_db,ped_req} = %b, expected 0000",
                         {tick, blink, btn_db, ped_req});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tick();
        ev_t  e;
        logic expBlink;
        applyReset(1'b0);
        tickQ.push_back(ev_t'{10, 1'b1});
        tickQ.push_back(ev_t'{20, 1'b0});
        tickQ.push_back(ev_t'{30, 1'b1});
        expBlink = 1'b0;
        for (int i = 0; i < 35; i++) begin
            stepCycle();
            vectors++;
            if (tick) begin
                if (tickQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL tick_extra: tick at clk %0d, no tick expected", cyc);
                end else begin
                    e = tickQ.pop_front();
                    expBlink = e.val;
                    if (cyc !== e.cyc || blink !== e.val) begin
                        miscompares++;
                        $display("[TB] FAIL tick_event: tick at clk %0d blink %b, expected clk %0d blink %b",
                                 cyc, blink, e.cyc, e.val);
                    end
                end
            end else if (blink !== expBlink) begin
                miscompares++;
                $display("[TB] FAIL blink_hold: blink %b at clk %0d, expected %b", blink, cyc, expBlink);
            end
        end
        vectors++;
        if (tickQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL tick_missing: %0d ticks never seen, expected 0", tickQ.size());
        end
    endtask

    task automatic test_pause();
        ev_t  e;
        logic expBlink;
        applyReset(1'b0);
        tickQ.push_back(ev_t'{10, 1'b1});
        tickQ.push_back(ev_t'{25, 1'b0});
        tickQ.push_back(ev_t'{35, 1'b1});
        expBlink = 1'b0;
        for (int i = 0; i < 40; i++) begin
            stepCycle();
            if (cyc == 14) en = 1'b0;
            if (cyc == 19) en = 1'b1;
            vectors++;
            if (tick) begin
                if (tickQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL pause_tick_extra: tick at clk %0d, no tick expected", cyc);
                end else begin
                    e = tickQ.pop_front();
                    expBlink = e.val;
                    if (cyc !== e.cyc || blink !== e.val) begin
                        miscompares++;
                        $display("[TB] FAIL pause_tick: tick at clk %0d blink %b, expected clk %0d blink %b",
                                 cyc, blink, e.cyc, e.val);
                    end
                end
            end else if (blink !== expBlink) begin
                miscompares++;
                $display("[TB] FAIL pause_blink: blink %b at clk %0d, expected %b", blink, cyc, expBlink);
            end
        end
        vectors++;
        if (tickQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pause_tick_missing: %0d ticks never seen, expected 0", tickQ.size());
        end
    endtask

    task automatic test_clean_press();
        logic prevDb;
        logic prevReq;
        int   expCyc;
        applyReset(1'b0);
        btn_raw = 1'b1;
        dbQ.push_back(6);
        reqQ.push_back(7);
        prevDb  = 1'b0;
        prevReq = 1'b0;
        for (int i = 0; i < 15; i++) begin
            stepCycle();
            if (btn_db && !prevDb) begin
                vectors++;
                expCyc = -1;
                if (dbQ.size() != 0) expCyc = dbQ.pop_front();
                if (cyc !== expCyc) begin
                    miscompares++;
                    $display("[TB] FAIL press_db_rise: btn_db rose at clk %0d, expected clk %0d", cyc, expCyc);
                end
            end
            if (ped_req && !prevReq) begin
                vectors++;
                expCyc = -1;
                if (reqQ.size() != 0) expCyc = reqQ.pop_front();
                if (cyc !== expCyc) begin
                    miscompares++;
                    $display("[TB] FAIL press_req_set: ped_req rose at clk %0d, expected clk %0d", cyc, expCyc);
                end
            end
            prevDb  = btn_db;
            prevReq = ped_req;
        end
        vectors++;
        if (dbQ.size() != 0 || reqQ.size() != 0 || ped_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL press_final: pending db %0d req %0d ped_req %b, expected 0 0 1",
                     dbQ.size(), reqQ.size(), ped_req);
        end
    endtask

    task automatic test_bounce();
        logic prevDb;
        logic prevReq;
        int   expCyc;
        applyReset(1'b0);
        btn_raw = 1'b1;
        dbQ.push_back(14);
        reqQ.push_back(15);
        prevDb  = 1'b0;
        prevReq = 1'b0;
        for (int i = 0; i < 25; i++) begin
            stepCycle();
            if (cyc == 2) btn_raw = 1'b0;
            if (cyc == 4) btn_raw = 1'b1;
            if (cyc == 6) btn_raw = 1'b0;
            if (cyc == 8) btn_raw = 1'b1;
            if (btn_db && !prevDb) begin
                vectors++;
                expCyc = -1;
                if (dbQ.size() != 0) expCyc = dbQ.pop_front();
                if (cyc !== expCyc) begin
                    miscompares++;
                    $display("[TB] FAIL bounce_db_rise: btn_db rose at clk %0d, expected clk %0d", cyc, expCyc);
                end
            end
            if (ped_req && !prevReq) begin
                vectors++;
                expCyc = -1;
                if (reqQ.size() != 0) expCyc = reqQ.pop_front();
                if (cyc !== expCyc) begin
                    miscompares++;
                    $display("[TB] FAIL bounce_req_set: ped_req rose at clk %0d, expected clk %0d", cyc, expCyc);
                end
            end
            prevDb  = btn_db;
            prevReq = ped_req;
        end
        vectors++;
        if (dbQ.size() != 0 || reqQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bounce_pending: db %0d req %0d events never seen, expected 0 0",
                     dbQ.size(), reqQ.size());
        end
    endtask

    task automatic test_ack_collision();
        logic prevDb;
        logic expReq;
        int   expCyc;
        int   n;
        applyReset(1'b0);
        dbQ.push_back(6);
        dbQ.push_back(22);
        prevDb = 1'b0;
        for (int i = 0; i < 33; i++) begin
            case (cyc)
                0:  btn_raw = 1'b1;
                10: btn_raw = 1'b0;
                16: btn_raw = 1'b1;
                22: req_ack = 1'b1;
                23: req_ack = 1'b0;
                26: req_ack = 1'b1;
                27: req_ack = 1'b0;
                29: req_ack = 1'b1;
                30: req_ack = 1'b0;
                default: ;
            endcase
            n = cyc + 1;
            reqExpQ.push_back((n >= 7 && n <= 26) ? 1'b1 : 1'b0);
            stepCycle();
            expReq = reqExpQ.pop_front();
            vectors++;
            if (ped_req !== expReq) begin
                miscompares++;
                $display("[TB] FAIL ack_ped_req: ped_req %b at clk %0d, expected %b", ped_req, cyc, expReq);
            end
            if (btn_db && !prevDb) begin
                vectors++;
                expCyc = -1;
                if (dbQ.size() != 0) expCyc = dbQ.pop_front();
                if (cyc !== expCyc) begin
                    miscompares++;
                    $display("[TB] FAIL ack_db_rise: btn_db rose at clk %0d, expected clk %0d", cyc, expCyc);
                end
            end
            prevDb = btn_db;
        end
        vectors++;
        if (dbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL ack_db_pending: %0d btn_db rises never seen, expected 0", dbQ.size());
        end
    endtask

    task automatic test_reset_mid();
        ev_t  e;
        logic prevDb;
        logic prevReq;
        int   expCyc;
        applyReset(1'b0);
        btn_raw = 1'b1;
        repeat (13) stepCycle();
        vectors++;
        if (ped_req !== 1'b1 || blink !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_setup: ped_req %b blink %b at clk 13, expected 1 1", ped_req, blink);
        end
        #2 clr_n = 1'b0;
        #1;
        vectors++;
        if ({tick, blink, btn_db, ped_req} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL midreset_async: {tick,blink,btn_db,ped_req} = %b, expected 0000",
                     {tick, blink, btn_db, ped_req});
        end
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;
        tickQ.push_back(ev_t'{10, 1'b1});
        dbQ.push_back(6);
        reqQ.push_back(7);
        prevDb  = 1'b0;
        prevReq = 1'b0;
        for (int i = 0; i < 15; i++) begin
            stepCycle();
            if (tick) begin
                vectors++;
                if (tickQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_tick_extra: tick at clk %0d, no tick expected", cyc);
                end else begin
                    e = tickQ.pop_front();
                    if (cyc !== e.cyc || blink !== e.val) begin
                        miscompares++;
                        $display("[TB] FAIL midreset_tick: tick at clk %0d blink %b, expected clk %0d blink %b",
                                 cyc, blink, e.cyc, e.val);
                    end
                end
            end
            if (btn_db && !prevDb) begin
                vectors++;
                expCyc = -1;
                if (dbQ.size() != 0) expCyc = dbQ.pop_front();
                if (cyc !== expCyc) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_db_rise: btn_db rose at clk %0d, expected clk %0d", cyc, expCyc);
                end
            end
            if (ped_req && !prevReq) begin
                vectors++;
                expCyc = -1;
                if (reqQ.size() != 0) expCyc = reqQ.pop_front();
                if (cyc !== expCyc) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_req_set: ped_req rose at clk %0d, expected clk %0d", cyc, expCyc);
                end
            end
            prevDb  = btn_db;
            prevReq = ped_req;
        end
        vectors++;
        if (tickQ.size() != 0 || dbQ.size() != 0 || reqQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_pending: tick %0d db %0d req %0d events never seen, expected 0 0 0",
                     tickQ.size(), dbQ.size(), reqQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_pause();
        test_clean_press();
        test_bounce();
        test_ack_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
